imem_boot_loader: RTL and testbench

// - Writer side of instruction-memory initialisation. Hardware replacement for the bench-side $readmemh preload.
// - Accepts a byte stream (header + big-endian words) and writes words into the instruction memory of mips_single.
// - Holds the CPU in reset until the image is complete, then releases it so execution starts from word address 0.

---
 rtl/imem_boot_loader.sv | 163 ++++++++++++++++
 tb/tb_imem_boot_loader.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: byte-stream loader for the mips_single instruction memory.
// The stream is a 2-byte big-endian word count N followed by N big-endian
// 32-bit words. Each complete word is written out with a one-cycle strobe.
// The CPU is held in reset until the whole image has been written.
// Optional feature macro: IMEM_BOOT_CHECKSUM_EN. When it is defined, one trailing
// byte must equal the XOR of all header and data bytes, or the load aborts.
module imem_boot_loader #(
    parameter int MEM_WORDS = 256,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA,
`ifdef IMEM_BOOT_CHECKSUM_EN
        CHK,
`endif
        RUN,
        ERR
    } state_t;

    // State entered once the header and data are complete, and whether
    // that state still takes bytes.
`ifdef IMEM_BOOT_CHECKSUM_EN
    localparam state_t FIN_ST  = CHK;
    localparam logic   FIN_RDY = 1'b1;
`else
    localparam state_t FIN_ST  = RUN;
    localparam logic   FIN_RDY = 1'b0;
`endif

    state_t      state;
    logic [15:0] nwords;     // word count from the header
    logic [15:0] wc;         // index of the word being assembled
    logic [1:0]  bc;         // byte position within the current word
    logic [23:0] asm_r;      // the first three bytes of the current word
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [7:0]  csum;       // running XOR of header and data bytes
`endif

    logic        xfer;
    logic [15:0] n_full;

    assign xfer   = in_valid & in_ready;
    assign n_full = {nwords[15:8], in_data};

    // Loader FSM. All outputs are registered. The final write strobe is
    // issued one cycle before done and the release of cpu_rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HDR_HI;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rst   <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            nwords    <= '0;
            wc        <= '0;
            bc        <= '0;
            asm_r     <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            case (state)
                HDR_HI: begin
                    in_ready <= 1'b1;
                    if (xfer) begin
                        nwords[15:8] <= in_data;
`ifdef IMEM_BOOT_CHECKSUM_EN
                        csum <= in_data;
`endif
                        state <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (xfer) begin
                        nwords[7:0] <= in_data;
`ifdef IMEM_BOOT_CHECKSUM_EN
                        csum <= csum ^ in_data;
`endif
                        wc <= '0;
                        bc <= '0;
                        if (n_full > 16'(MEM_WORDS)) begin
                            state    <= ERR;
                            in_ready <= 1'b0;
                            err      <= 1'b1;
                        end else if (n_full == 16'd0) begin
                            state    <= FIN_ST;
                            in_ready <= FIN_RDY;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        asm_r <= {asm_r[15:0], in_data};
                        bc    <= bc + 2'd1;
`ifdef IMEM_BOOT_CHECKSUM_EN
                        csum  <= csum ^ in_data;
`endif
                        if (bc == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= wc[ADDR_W-1:0];
                            mem_wdata <= {asm_r, in_data};
                            wc        <= wc + 16'd1;
                            if (wc == nwords - 16'd1) begin
                                state    <= FIN_ST;
                                in_ready <= FIN_RDY;
                            end
                        end
                    end
                end
`ifdef IMEM_BOOT_CHECKSUM_EN
                CHK: begin
                    if (xfer) begin
                        in_ready <= 1'b0;
                        if (in_data == csum) begin
                            state <= RUN;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif
                RUN: begin
                    in_ready <= 1'b0;
                    cpu_rst  <= 1'b0;
                    done     <= 1'b1;
                end
                ERR: begin
                    in_ready <= 1'b0;
                    cpu_rst  <= 1'b1;
                    err      <= 1'b1;
                end
                default: begin
                    state    <= ERR;
                    in_ready <= 1'b0;
                    err      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader. It uses randomized streams and checks the DUT
// against a stream-level reference model.
module tb_imem_boot_loader;

    typedef logic [7:0] b_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, mem_we, cpu_rst, done, err;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;

    int total = 0;
    int bad = 0;
    int inv_bad = 0;

    int          got_addr[$];
    logic [31:0] got_data[$];
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    bit          exp_done, exp_err;

    imem_boot_loader #(.MEM_WORDS(256), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_rst(cpu_rst), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Record every memory write strobe.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            got_addr.push_back(int'(mem_addr));
            got_data.push_back(mem_wdata);
        end
    end

    // Check cycle-level invariants: cpu_rst is released only while done is
    // set, no write occurs while the CPU runs, and err keeps the CPU in reset.
    always @(negedge clk) begin
        if (cpu_rst !== ~done) inv_bad++;
        if (mem_we === 1'b1 && cpu_rst !== 1'b1) inv_bad++;
        if (err === 1'b1 && cpu_rst !== 1'b1) inv_bad++;
    end

    // Reference model. It decodes the stream and lists the expected writes
    // and the final outcome.
    task automatic model(input b_t s[$]);
        int n;
        exp_addr.delete();
        exp_data.delete();
        exp_done = 0;
        exp_err  = 0;
        n = int'(s[0]) * 256 + int'(s[1]);
        if (n > 256) begin
            exp_err = 1;
            return;
        end
        for (int w = 0; w < n; w++) begin
            exp_addr.push_back(w);
            exp_data.push_back({s[2+4*w], s[3+4*w], s[4+4*w], s[5+4*w]});
        end
`ifdef IMEM_BOOT_CHECKSUM_EN
        begin
            b_t x = 8'h00;
            for (int i = 0; i < 2 + 4 * n; i++) x ^= s[i];
            if (s[2+4*n] == x) exp_done = 1;
            else exp_err = 1;
        end
`else
        exp_done = 1;
`endif
    endtask

    // Build a stream from a word list. With the checksum feature enabled,
    // append the trailing byte, corrupted when asked.
    task automatic build(input logic [31:0] words[$], input bit corrupt, output b_t s[$]);
        b_t x;
        s.delete();
        s.push_back(b_t'(words.size() >> 8));
        s.push_back(b_t'(words.size()));
        foreach (words[i]) begin
            s.push_back(words[i][31:24]);
            s.push_back(words[i][23:16]);
            s.push_back(words[i][15:8]);
            s.push_back(words[i][7:0]);
        end
        x = 8'h00;
        foreach (s[i]) x ^= s[i];
`ifdef IMEM_BOOT_CHECKSUM_EN
        s.push_back(corrupt ? ~x : x);
`else
        if (corrupt) x = 8'h00;
`endif
    endtask

    // Drive a stream. gap: 0 = none, 1 = in_valid toggles, 2 = random.
    // Then check the outcome timing and the recorded writes.
    task automatic run_stream(input string name, input b_t s[$], input int gap);
        int idx = 0;
        int cyc = 0;
        got_addr.delete();
        got_data.delete();
        model(s);
        while (idx < s.size() && cyc < 20000) begin
            @(negedge clk);
            case (gap)
                0: in_valid = 1'b1;
                1: in_valid = (cyc % 2) == 0;
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = s[idx];
            if (in_valid && in_ready === 1'b1) idx++;
            cyc++;
        end
        total++;
        if (idx < s.size()) begin
            bad++;
            $display("FAIL %s timeout: accepted=%0d required=%0d", name, idx, s.size());
        end
        // Cycle 1 after the last accepted byte.
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (exp_err) begin
            if (err !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL %s err_c1: err=%b cpu_rst=%b done=%b required 1 1 0", name, err, cpu_rst, done);
            end
        end else if (done !== 1'b0 || cpu_rst !== 1'b1) begin
            bad++;
            $display("FAIL %s done_c1: done=%b cpu_rst=%b required 0 1", name, done, cpu_rst);
        end
`ifndef IMEM_BOOT_CHECKSUM_EN
        if (exp_addr.size() > 0) begin
            total++;
            if (mem_we !== 1'b1) begin
                bad++;
                $display("FAIL %s last_strobe: mem_we=%b required 1", name, mem_we);
            end
        end
`endif
        // Cycle 2 after the last accepted byte.
        @(negedge clk);
        total++;
        if (done !== exp_done || err !== exp_err || cpu_rst !== !exp_done) begin
            bad++;
            $display("FAIL %s outcome: done=%b err=%b cpu_rst=%b required %b %b %b",
                     name, done, err, cpu_rst, exp_done, exp_err, !exp_done);
        end
        repeat (3) @(negedge clk);
        total++;
        if (got_addr.size() != exp_addr.size()) begin
            bad++;
            $display("FAIL %s write_count: got=%0d required=%0d", name, got_addr.size(), exp_addr.size());
        end else begin
            foreach (exp_addr[i]) begin
                total++;
                if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                    bad++;
                    $display("FAIL %s write[%0d]: got (%0d,%h) required (%0d,%h)",
                             name, i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
                end
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, err} !==
            {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_vals: rdy=%b we=%b addr=%h wd=%h cpu_rst=%b done=%b err=%b",
                     in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, err);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready_rise: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_basic(input int gap, input string name);
        b_t s[$];
        logic [31:0] w[$];
        w = '{32'h20080005, 32'hAC080004};
        build(w, 0, s);
        pulse_reset();
        run_stream(name, s, gap);
    endtask

    task automatic test_overflow();
        b_t s[$];
        s = '{8'h01, 8'h01};
        pulse_reset();
        run_stream("overflow", s, 0);
    endtask

    task automatic test_empty();
        b_t s[$];
        logic [31:0] w[$];
        w.delete();
        build(w, 0, s);
        pulse_reset();
        run_stream("empty", s, 0);
    endtask

    task automatic test_rst_mid();
        b_t s[$];
        int idx = 0;
        int cyc = 0;
        s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05};
        pulse_reset();
        while (idx < 6 && cyc < 1000) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data = s[idx];
            if (in_ready === 1'b1) idx++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (cpu_rst !== 1'b1 || mem_we !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_pulse: cpu_rst=%b mem_we=%b in_ready=%b done=%b required 1 0 0 0",
                     cpu_rst, mem_we, in_ready, done);
        end
        rst = 1'b0;
        s = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
`ifdef IMEM_BOOT_CHECKSUM_EN
        s.push_back(8'h01);
`endif
        run_stream("rst_mid_reload", s, 0);
    endtask

    task automatic test_random();
        b_t s[$];
        logic [31:0] w[$];
        for (int t = 0; t < 8; t++) begin
            w.delete();
            for (int i = 0; i < int'($urandom_range(1, 6)); i++) w.push_back($urandom);
            build(w, ($urandom_range(0, 3) == 0), s);
            pulse_reset();
            run_stream($sformatf("random%0d", t), s, 2);
        end
    endtask

    task automatic test_full();
        b_t s[$];
        logic [31:0] w[$];
        for (int i = 0; i < 256; i++) w.push_back($urandom);
        build(w, 0, s);
        pulse_reset();
        run_stream("full256", s, 0);
        total++;
        if (got_addr.size() == 0 || got_addr[got_addr.size()-1] !== 255) begin
            bad++;
            $display("FAIL full_last_addr: got=%0d required=255",
                     got_addr.size() ? got_addr[got_addr.size()-1] : -1);
        end
    endtask

    task automatic test_run_ignore();
        int n0;
        n0 = got_addr.size();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data = 8'($urandom);
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL run_ignore_ready: in_ready=%b required 0", in_ready);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (got_addr.size() != n0 || done !== 1'b1) begin
            bad++;
            $display("FAIL run_ignore_writes: writes=%0d required=%0d done=%b", got_addr.size(), n0, done);
        end
    endtask

    task automatic test_checksum_bad();
        b_t s[$];
        logic [31:0] w[$];
        w = '{32'h20080005, 32'hAC080004};
        build(w, 1, s);
        pulse_reset();
        run_stream("checksum_bad", s, 0);
    endtask

    task automatic test_invariants();
        total++;
        if (inv_bad !== 0) begin
            bad++;
            $display("FAIL invariants: violations=%0d required=0", inv_bad);
        end
    endtask

    initial begin
        test_reset();
        test_basic(0, "basic");
        test_run_ignore();
        test_overflow();
        test_empty();
        test_basic(1, "toggle");
        test_rst_mid();
        test_random();
        test_full();
        test_checksum_bad();
        test_invariants();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
